// File: rtl/sine_nco_pkg.sv
// Shared types and constants for the sine NCO front-end that feeds the CORDIC Sine core.
package sine_nco_pkg;

   localparam int unsigned ANGLE_W  = 16;
   localparam int unsigned SAMPLE_W = 16;

   // pi/2 in the core's Q3.13 radian format
   localparam logic [ANGLE_W-1:0] HALF_PI_CODE = 16'h3244;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2,
      EMIT   = 2'd3
   } seq_state_e;

   typedef enum logic [1:0] {
      QUAD_0 = 2'd0,
      QUAD_1 = 2'd1,
      QUAD_2 = 2'd2,
      QUAD_3 = 2'd3
   } quadrant_e;

endpackage

// File: rtl/sine_phase_sequencer_phase_to_angle.sv
// Combinational fold of a full-circle phase into the core's [0, pi/2] angle range,
// plus the sign to restore on the core's result.
module phase_to_angle #(
   parameter int unsigned PHASE_W = 32,
   parameter int unsigned FRAC_W  = 14,
   parameter logic [sine_nco_pkg::ANGLE_W-1:0] HALF_PI_CODE = sine_nco_pkg::HALF_PI_CODE
) (
   input  logic [PHASE_W-1:0]                Phase_i,
   output logic [sine_nco_pkg::ANGLE_W-1:0]  Angle_o,
   output logic                              Neg_o
);
   import sine_nco_pkg::*;

   localparam int unsigned PROD_W = FRAC_W + ANGLE_W;

   quadrant_e           quad;
   logic [FRAC_W-1:0]   frac;
   logic [PROD_W-1:0]   prod;
   logic [ANGLE_W-1:0]  f_angle;
   logic                bits_unused;

   assign quad    = quadrant_e'(Phase_i[PHASE_W-1 -: 2]);
   assign frac    = Phase_i[PHASE_W-3 -: FRAC_W];
   assign prod    = PROD_W'(frac) * PROD_W'(HALF_PI_CODE);
   assign f_angle = prod[FRAC_W +: ANGLE_W];

   assign bits_unused = ^{Phase_i[PHASE_W-3-FRAC_W:0], prod[FRAC_W-1:0]};

   // Odd quadrants mirror the ramp so the angle falls back from pi/2 towards 0
   always_comb begin
      Angle_o = f_angle;
      Neg_o   = 1'b0;
      unique case (quad)
         QUAD_0: begin
            Angle_o = f_angle;
            Neg_o   = 1'b0;
         end
         QUAD_1: begin
            Angle_o = HALF_PI_CODE - f_angle;
            Neg_o   = 1'b0;
         end
         QUAD_2: begin
            Angle_o = f_angle;
            Neg_o   = 1'b1;
         end
         QUAD_3: begin
            Angle_o = HALF_PI_CODE - f_angle;
            Neg_o   = 1'b1;
         end
         default: begin
            Angle_o = f_angle;
            Neg_o   = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/sine_phase_sequencer.sv
// NCO front-end: phase accumulator, quadrant fold, Start/Done handshake with the
// CORDIC Sine core, and sign restoration of the returned sample.
module sine_phase_sequencer #(
   parameter int unsigned PHASE_W = 32,
   parameter int unsigned FRAC_W  = 14,
   parameter logic [sine_nco_pkg::ANGLE_W-1:0] HALF_PI_CODE = sine_nco_pkg::HALF_PI_CODE
) (
   input  logic                                Clk_i,
   input  logic                                Rst_i,
   input  logic                                Enable_i,
   input  logic                                SampleTick_i,
   input  logic [PHASE_W-1:0]                  PhaseInc_i,
   input  logic                                PhaseClr_i,
   input  logic                                OvrClr_i,
   output logic [sine_nco_pkg::ANGLE_W-1:0]    Angle_o,
   output logic                                Start_o,
   input  logic                                Done_i,
   input  logic [sine_nco_pkg::SAMPLE_W-1:0]   Sine_i,
   output logic [sine_nco_pkg::SAMPLE_W-1:0]   Sample_o,
   output logic                                SampleValid_o,
   output logic                                Busy_o,
   output logic                                Overrun_o
);
   import sine_nco_pkg::*;

   seq_state_e            state_q, state_d;
   logic [PHASE_W-1:0]    acc_q, acc_d;
   logic [ANGLE_W-1:0]    angle_q, angle_d;
   logic                  neg_q, neg_d;
   logic [SAMPLE_W-1:0]   sample_q, sample_d;
   logic                  ovr_q, ovr_d;

   logic [ANGLE_W-1:0]    fold_angle;
   logic                  fold_neg;
   logic                  accept;
   logic                  drop;
   logic [SAMPLE_W-1:0]   restored;

   // The fold sees the pre-increment accumulator, i.e. the phase of this sample
   phase_to_angle #(
      .PHASE_W      (PHASE_W),
      .FRAC_W       (FRAC_W),
      .HALF_PI_CODE (HALF_PI_CODE)
   ) u_fold (
      .Phase_i (acc_q),
      .Angle_o (fold_angle),
      .Neg_o   (fold_neg)
   );

   always_ff @(posedge Clk_i or posedge Rst_i) begin
      if (Rst_i) begin
         state_q  <= IDLE;
         acc_q    <= '0;
         angle_q  <= '0;
         neg_q    <= 1'b0;
         sample_q <= '0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         angle_q  <= angle_d;
         neg_q    <= neg_d;
         sample_q <= sample_d;
         ovr_q    <= ovr_d;
      end
   end

   always_comb begin
      restored = Sine_i;
      if (neg_q) begin
         restored = (Sine_i == {1'b1, {(SAMPLE_W-1){1'b0}}}) ? {1'b0, {(SAMPLE_W-1){1'b1}}}
                                                             : (~Sine_i + 1'b1);
      end
   end

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      angle_d  = angle_q;
      neg_d    = neg_q;
      sample_d = sample_q;
      ovr_d    = ovr_q;

      accept = (state_q == IDLE) && Enable_i && SampleTick_i;
      drop   = (state_q != IDLE) && Enable_i && SampleTick_i;

      if (accept) begin
         acc_d   = acc_q + PhaseInc_i;
         angle_d = fold_angle;
         neg_d   = fold_neg;
      end
      if (PhaseClr_i) begin
         acc_d = '0;
      end

      // A fresh overrun outranks a coincident clear request
      if (drop) begin
         ovr_d = 1'b1;
      end else if (OvrClr_i) begin
         ovr_d = 1'b0;
      end

      unique case (state_q)
         IDLE:   if (accept) state_d = LAUNCH;
         LAUNCH: state_d = WAIT;
         WAIT: begin
            if (Done_i) begin
               sample_d = restored;
               state_d  = EMIT;
            end
         end
         EMIT:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign Angle_o       = angle_q;
   assign Start_o       = (state_q == LAUNCH);
   assign SampleValid_o = (state_q == EMIT);
   assign Busy_o        = (state_q != IDLE);
   assign Sample_o      = sample_q;
   assign Overrun_o     = ovr_q;

endmodule

// File: tb/tb_sine_phase_sequencer.sv
// Scoreboard bench for sine_phase_sequencer with a behavioural CORDIC core stand-in.
module tb_sine_phase_sequencer;

   localparam longint HP      = 12868;
   localparam longint QUARTER = 64'd1073741824;
   localparam longint CIRCLE  = 64'd4294967296;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        tick;
   logic [31:0] inc;
   logic        clr;
   logic        ovrclr;
   logic [15:0] angle_o;
   logic        start_o;
   logic        done;
   logic [15:0] sine;
   logic [15:0] sample_o;
   logic        sv_o;
   logic        busy_o;
   logic        ovr_o;

   always #5 clk = ~clk;

   sine_phase_sequencer #(
      .PHASE_W      (32),
      .FRAC_W       (14),
      .HALF_PI_CODE (16'h3244)
   ) dut (
      .Clk_i         (clk),
      .Rst_i         (rst),
      .Enable_i      (en),
      .SampleTick_i  (tick),
      .PhaseInc_i    (inc),
      .PhaseClr_i    (clr),
      .OvrClr_i      (ovrclr),
      .Angle_o       (angle_o),
      .Start_o       (start_o),
      .Done_i        (done),
      .Sine_i        (sine),
      .Sample_o      (sample_o),
      .SampleValid_o (sv_o),
      .Busy_o        (busy_o),
      .Overrun_o     (ovr_o)
   );

   typedef struct {
      longint angle;
      bit     neg;
   } exp_t;

   exp_t   exp_q[$];
   exp_t   fl_q[$];
   longint sine_q[$];

   int     compared   = 0;
   int     mismatched = 0;
   longint acc_m      = 0;
   int     accepted   = 0;
   int     start_cnt  = 0;
   int     emit_cnt   = 0;
   longint last_angle = -1;
   longint last_sample = -1;

   int          core_lat  = 16;
   bit          core_rand = 1'b0;
   bit          force_en  = 1'b0;
   logic [15:0] force_val = 16'h0;
   bit          stray_req = 1'b0;

   task automatic chk(input string name, input longint act, input longint req);
      compared++;
      if (act != req) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic fail(input string name);
      compared++;
      mismatched++;
      $display("FAIL %s", name);
   endtask

   // Fold straight from the circle geometry: quarter-turn index and fraction of it
   function automatic exp_t ref_fold(input longint ph);
      exp_t   r;
      longint quad = ph / QUARTER;
      longint frac = (ph % QUARTER) / 65536;
      longint f    = (frac * HP) / 16384;
      r.angle = (quad % 2 == 1) ? HP - f : f;
      r.neg   = (quad >= 2);
      return r;
   endfunction

   function automatic longint ref_sample(input longint s, input bit neg);
      if (!neg) return s;
      if (s == -32768) return 32767;
      return -s;
   endfunction

   // Core stand-in: Done_i core_lat cycles after Start_o, echoing the angle by default
   initial begin
      int          cnt = 0;
      logic [15:0] cap = '0;
      logic [15:0] val;
      done = 1'b0;
      sine = '0;
      forever begin
         @(negedge clk);
         done = 1'b0;
         if (rst) begin
            cnt = 0;
         end else if (stray_req) begin
            stray_req = 1'b0;
            done = 1'b1;
            sine = 16'h1234;
         end else if (start_o) begin
            cnt = core_lat;
            cap = angle_o;
         end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               val  = force_en ? force_val : (core_rand ? 16'($urandom) : cap);
               done = 1'b1;
               sine = val;
               sine_q.push_back(longint'($signed(val)));
            end
         end
      end
   end

   // Monitor
   initial begin
      exp_t   e;
      longint s;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (start_o) begin
               start_cnt++;
               if (exp_q.size() == 0) begin
                  fail("unexpected_start");
               end else begin
                  e = exp_q.pop_front();
                  chk("angle_at_start", longint'(angle_o), e.angle);
                  last_angle = longint'(angle_o);
                  fl_q.push_back(e);
               end
            end
            if (sv_o) begin
               emit_cnt++;
               if (fl_q.size() == 0 || sine_q.size() == 0) begin
                  fail("unexpected_sample");
               end else begin
                  e = fl_q.pop_front();
                  s = sine_q.pop_front();
                  chk("angle_hold", longint'(angle_o), e.angle);
                  chk("sample", longint'($signed(sample_o)), ref_sample(s, e.neg));
                  last_sample = longint'(sample_o);
               end
            end
         end
      end
   end

   task automatic tick_once(input logic [31:0] i, input bit c, input bit e, input bit exp_acc);
      @(negedge clk);
      inc  = i;
      clr  = c;
      en   = e;
      tick = 1'b1;
      if (exp_acc) begin
         exp_q.push_back(ref_fold(acc_m));
         accepted++;
         acc_m = c ? 0 : (acc_m + longint'(i)) % CIRCLE;
      end else if (c) begin
         acc_m = 0;
      end
      @(negedge clk);
      tick = 1'b0;
      clr  = 1'b0;
   endtask

   task automatic wait_emits();
      for (int k = 0; k < 500 && emit_cnt < accepted; k++) @(negedge clk);
      if (emit_cnt < accepted) fail("sample_timeout");
      @(negedge clk);
   endtask

   task automatic clear_acc();
      @(negedge clk);
      clr = 1'b1;
      acc_m = 0;
      @(negedge clk);
      clr = 1'b0;
   endtask

   task automatic pulse_ovrclr();
      @(negedge clk);
      ovrclr = 1'b1;
      @(negedge clk);
      ovrclr = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; en = 1'b0; tick = 1'b0; clr = 1'b0; ovrclr = 1'b0; inc = '0;
      repeat (2) @(negedge clk);
      chk("rst_angle", longint'(angle_o), 0);
      chk("rst_start", longint'(start_o), 0);
      chk("rst_sample", longint'(sample_o), 0);
      chk("rst_valid", longint'(sv_o), 0);
      chk("rst_busy", longint'(busy_o), 0);
      chk("rst_ovr", longint'(ovr_o), 0);
      rst = 1'b0;
      en  = 1'b1;

      // Quarter-turn steps through all four quadrants, echo core
      for (int n = 0; n < 4; n++) begin
         tick_once(32'h4000_0000, 1'b0, 1'b1, 1'b1);
         wait_emits();
      end
      chk("q3_angle", last_angle, 64'h3244);
      chk("q3_sample", last_sample, 64'hCDBC);

      // pi/6 point
      clear_acc();
      for (int n = 0; n < 2; n++) begin
         tick_once(32'h1555_5555, 1'b0, 1'b1, 1'b1);
         wait_emits();
      end
      chk("pi6_angle", last_angle, 64'h10C1);

      // Overrun during WAIT, then clear
      tick_once(32'h0123_4567, 1'b0, 1'b1, 1'b1);
      repeat (4) @(negedge clk);
      tick_once(32'h0, 1'b0, 1'b1, 1'b0);
      chk("ovr_set", longint'(ovr_o), 1);
      wait_emits();
      repeat (20) @(negedge clk);
      chk("one_emit", longint'(emit_cnt), longint'(accepted));
      pulse_ovrclr();
      chk("ovr_clr", longint'(ovr_o), 0);

      // Set beats a coincident clear
      tick_once(32'h0765_4321, 1'b0, 1'b1, 1'b1);
      repeat (4) @(negedge clk);
      @(negedge clk);
      tick = 1'b1; ovrclr = 1'b1;
      @(negedge clk);
      tick = 1'b0; ovrclr = 1'b0;
      chk("ovr_set_wins", longint'(ovr_o), 1);
      wait_emits();
      pulse_ovrclr();
      chk("ovr_clr2", longint'(ovr_o), 0);

      // Saturating negation in quadrant 3
      clear_acc();
      tick_once(32'hC000_0000, 1'b0, 1'b1, 1'b1);
      wait_emits();
      force_en = 1'b1; force_val = 16'h8000;
      tick_once(32'h0, 1'b0, 1'b1, 1'b1);
      wait_emits();
      chk("sat_sample", last_sample, 64'h7FFF);

      // Clear coincident with an accepted tick
      force_val = 16'h1000;
      clear_acc();
      tick_once(32'h8000_0000, 1'b0, 1'b1, 1'b1);
      wait_emits();
      tick_once(32'h1234_5678, 1'b1, 1'b1, 1'b1);
      wait_emits();
      chk("clr_tick_sample", last_sample, 64'hF000);
      tick_once(32'h0, 1'b0, 1'b1, 1'b1);
      wait_emits();
      chk("after_clr_sample", last_sample, 64'h1000);
      force_en = 1'b0;

      // Disabled ticks: ignored when idle and when busy, no overrun
      tick_once(32'h1111_1111, 1'b0, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      chk("dis_busy", longint'(busy_o), 0);
      tick_once(32'h0222_2222, 1'b0, 1'b1, 1'b1);
      repeat (3) @(negedge clk);
      tick_once(32'h1111_1111, 1'b0, 1'b0, 1'b0);
      wait_emits();
      chk("dis_ovr", longint'(ovr_o), 0);
      en = 1'b1;

      // Done outside WAIT
      stray_req = 1'b1;
      repeat (4) @(negedge clk);
      chk("stray_busy", longint'(busy_o), 0);

      // Asynchronous reset while waiting on the core
      tick_once(32'h3333_3333, 1'b0, 1'b1, 1'b1);
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_start", longint'(start_o), 0);
      chk("arst_valid", longint'(sv_o), 0);
      chk("arst_busy", longint'(busy_o), 0);
      repeat (2) @(negedge clk);
      exp_q.delete(); fl_q.delete(); sine_q.delete();
      acc_m = 0;
      accepted = emit_cnt;
      start_cnt = emit_cnt;
      rst = 1'b0;
      tick_once(32'h4000_0000, 1'b0, 1'b1, 1'b1);
      wait_emits();
      chk("post_rst_angle", last_angle, 0);

      // Randomised phase steps, core latency and core results
      core_rand = 1'b1;
      for (int n = 0; n < 40; n++) begin
         core_lat = int'($urandom_range(1, 24));
         tick_once($urandom, ($urandom_range(0, 7) == 0), 1'b1, 1'b1);
         wait_emits();
      end

      repeat (10) @(negedge clk);
      chk("start_count", longint'(start_cnt), longint'(accepted));
      chk("emit_count", longint'(emit_cnt), longint'(accepted));
      chk("final_ovr", longint'(ovr_o), 0);
      chk("final_busy", longint'(busy_o), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
